// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions (adder flag layout, result-stage buffer states)
package alu_pkg;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;
  function automatic logic [3:0] add_flags(input logic [31:0] a, input logic [31:0] b, input logic [32:0] s);
    logic [3:0] f;
    f[FLAG_N] = s[31];
    f[FLAG_Z] = ~|s[31:0];
    f[FLAG_C] = s[32];
    f[FLAG_V] = (a[31] == b[31]) && (s[31] != a[31]);
    return f;
  endfunction
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry skid buffer with registered in_ready/out_valid
module skid_buf2
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  buf_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d, skid_q, skid_d;
  logic        in_ready_q, out_valid_q, in_xfer, out_xfer;
  assign in_xfer     = in_valid_i & in_ready_q;
  assign out_xfer    = out_valid_q & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = head_q;
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        state_d = in_xfer ? BUF_ONE : BUF_EMPTY;
        head_d  = in_xfer ? in_data_i : head_q;
      end
      BUF_ONE: begin
        state_d = (in_xfer & ~out_xfer) ? BUF_FULL : (out_xfer & ~in_xfer) ? BUF_EMPTY : BUF_ONE;
        head_d  = (in_xfer & out_xfer) ? in_data_i : head_q;
        skid_d  = (in_xfer & ~out_xfer) ? in_data_i : skid_q;
      end
      BUF_FULL: begin
        state_d = out_xfer ? BUF_ONE : BUF_FULL;
        head_d  = out_xfer ? skid_q : head_q;
      end
      default: state_d = BUF_EMPTY;
    endcase
  end
  // handshake outputs are registered from the next state so neither side sees a combinational path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= state_d != BUF_FULL;
      out_valid_q <= state_d != BUF_EMPTY;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers adder results, holds the NZCV register and counts overflows
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_flags,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count
);
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_xfer;
  skid_buf2 #(.W(WIDTH)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_result),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_result)
  );
  assign set_xfer = in_valid & in_ready & in_setflags;
  always_comb begin
    flags_d = set_xfer ? in_flags : flags_q;
    cnt_d   = (set_xfer & in_flags[FLAG_V] & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_flags = flags_q;
  assign ovf_count = cnt_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table vectors, corner sequences and random traffic against a queue model
module tb_alu_result_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_setflags = 1'b0, out_ready = 1'b0;
  logic [31:0] in_result = '0;
  logic [3:0]  in_flags = '0;
  logic        in_ready, out_valid, s_in_ready, s_out_valid;
  logic [31:0] out_result, s_out_result;
  logic [3:0]  out_flags, s_out_flags;
  logic [15:0] ovf_count;
  logic [1:0]  s_ovf_count;

  alu_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_setflags(in_setflags), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .ovf_count(ovf_count)
  );
  alu_result_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_setflags(in_setflags), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_flags(s_out_flags), .ovf_count(s_ovf_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, n_out = 0;
  logic [31:0] mq[$];
  logic [3:0]  mflags = '0;
  int          mcnt = 0, mcnt2 = 0;

  typedef struct {
    logic iv; logic [31:0] res; logic [3:0] fl; logic sf; logic ordy;
    logic ev; logic [31:0] er; logic [3:0] ef; logic [15:0] ec; logic erdy;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mflags = '0;
    mcnt   = 0;
    mcnt2  = 0;
  endtask

  // one clock: drive, advance the occupancy model across the edge, compare #1 after it
  task automatic step(input logic iv, input logic [31:0] res, input logic [3:0] fl, input logic sf, input logic ordy);
    bit ixf, oxf;
    in_valid = iv; in_result = res; in_flags = fl; in_setflags = sf; out_ready = ordy;
    ixf = iv && (mq.size() < 2);
    oxf = ordy && (mq.size() > 0);
    if (out_valid && ordy) n_out++;
    @(posedge clk);
    if (oxf) void'(mq.pop_front());
    if (ixf) begin
      mq.push_back(res);
      if (sf) begin
        mflags = fl;
        if (fl[0]) begin
          mcnt  = (mcnt < 65535) ? mcnt + 1 : mcnt;
          mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : mcnt2;
        end
      end
    end
    #1;
    chk("valid", out_valid, mq.size() > 0);
    chk("ready", in_ready, mq.size() < 2);
    if (mq.size() > 0) chk("result", out_result, mq[0]);
    chk("flags", out_flags, mflags);
    chk("ovf_count", ovf_count, mcnt);
    chk("ovf_count_sat", s_ovf_count, mcnt2);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_count", ovf_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  initial begin
    tbl[0] = '{1, 32'd12,        4'b0000, 1, 1, 1, 32'd12,        4'b0000, 16'd0, 1};
    tbl[1] = '{1, 32'hFFFFFFFE,  4'b1001, 1, 1, 1, 32'hFFFFFFFE,  4'b1001, 16'd1, 1};
    tbl[2] = '{1, 32'd7,         4'b0001, 0, 1, 1, 32'd7,         4'b1001, 16'd1, 1};
    tbl[3] = '{0, 32'd99,        4'b1111, 1, 1, 0, 32'd0,         4'b1001, 16'd1, 1};
    tbl[4] = '{1, 32'hFFFFFFF1,  4'b1000, 1, 0, 1, 32'hFFFFFFF1,  4'b1000, 16'd1, 1};
    tbl[5] = '{1, 32'd5,         4'b0000, 0, 0, 1, 32'hFFFFFFF1,  4'b1000, 16'd1, 0};
    tbl[6] = '{1, 32'd77,        4'b0001, 1, 0, 1, 32'hFFFFFFF1,  4'b1000, 16'd1, 0};
    tbl[7] = '{0, 32'd0,         4'b0000, 0, 1, 1, 32'd5,         4'b1000, 16'd1, 1};
    tbl[8] = '{0, 32'd0,         4'b0000, 0, 1, 0, 32'd0,         4'b1000, 16'd1, 1};

    @(posedge clk); #1;
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].res, tbl[i].fl, tbl[i].sf, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].erdy);
      if (tbl[i].ev) chk($sformatf("tbl%0d_result", i), out_result, tbl[i].er);
      chk($sformatf("tbl%0d_flags", i), out_flags, tbl[i].ef);
      chk($sformatf("tbl%0d_count", i), ovf_count, tbl[i].ec);
    end

    do_reset();
    step(1, 32'd5, 4'd0, 0, 0);
    chk("bp_ready1", in_ready, 1);
    step(1, 32'hFFFFFFF1, 4'd0, 0, 0);
    chk("bp_ready2", in_ready, 0);
    chk("bp_first", out_result, 5);
    step(0, 32'd0, 4'd0, 0, 1);
    chk("bp_second", out_result, 32'hFFFFFFF1);
    chk("bp_ready3", in_ready, 1);
    step(0, 32'd0, 4'd0, 0, 1);

    do_reset();
    repeat (4) step(1, 32'd3, 4'b0001, 1, 1);
    chk("sat_count", s_ovf_count, 3);
    chk("wide_count", ovf_count, 4);

    do_reset();
    n_out = 0;
    for (int i = 1; i <= 101; i++) begin
      step(i <= 100, 32'(i), 4'd0, 0, 1);
      if (i <= 100) chk("thru_nobubble", out_valid, 1);
    end
    chk("thru_count", n_out, 100);

    do_reset();
    step(1, 32'hDEAD0001, 4'b0001, 1, 0);
    step(1, 32'hDEAD0002, 4'b0001, 1, 0);
    chk("full_ready", in_ready, 0);
    do_reset();
    step(1, 32'h00000042, 4'b0000, 0, 1);
    chk("after_rst_result", out_result, 32'h42);
    step(0, 32'd0, 4'd0, 0, 1);
    chk("after_rst_empty", out_valid, 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
